// File: rtl/multichannel_sample_collector.sv
// multichannel_sample_collector
// Collects channel-tagged ADC samples, decimates each channel independently,
// packs one decimated value per channel into a frame and stores frames in a
// two-bank BRAM. A full bank is handed to the reader through a
// bank_ready/bank_ack handshake; a wrap while the reader still owns the other
// bank sets the sticky overrun flag.
// Optional build macro: DECIM_AVG_EN (average the DECIM samples instead of
// keeping the last one).
module multichannel_sample_collector #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DECIM  = 1,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned FR_W  = $clog2(DEPTH)
) (
  input  logic              CLK104MHZ,
  input  logic              rst,
  input  logic              capture_en,
  input  logic              sample_valid,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [FR_W-1:0]   read_frame,
  input  logic [CH_W-1:0]   read_ch,
  output logic [DATA_W-1:0] read_data,
  output logic              bank_ready,
  output logic              read_bank,
  input  logic              bank_ack,
  output logic              overrun,
  output logic              capture_active
);

  localparam int unsigned DEC_W     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW        = 1 + FR_W + CH_W;
  // Address is {bank, frame, channel}; for power-of-two NUM_CH this is
  // exactly 2*DEPTH*NUM_CH words.
  localparam int unsigned MEM_WORDS = 1 << AW;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                wbank_q, wbank_d;
  logic [FR_W-1:0]     wr_frame_q, wr_frame_d;
  logic [NUM_CH-1:0]   chan_done_q, chan_done_d;
  logic [DEC_W-1:0]    dcnt_q [NUM_CH];
  logic [DEC_W-1:0]    dcnt_d [NUM_CH];
  logic                bank_ready_q, bank_ready_d;
  logic                read_bank_q, read_bank_d;
  logic                overrun_q, overrun_d;
  logic                capture_active_q, capture_active_d;
  logic [DATA_W-1:0]   read_data_q;

`ifdef DECIM_AVG_EN
  localparam int unsigned LOG2D = $clog2(DECIM);
  localparam int unsigned ACC_W = DATA_W + LOG2D;
  logic [ACC_W-1:0]    acc_q [NUM_CH];
  logic [ACC_W-1:0]    acc_d [NUM_CH];
  logic [ACC_W-1:0]    sum;
`endif

  logic                accept;
  logic                ready_eff;
  logic                fire;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   dec_val;
  logic [NUM_CH-1:0]   done_next;

  logic [DATA_W-1:0]   mem [MEM_WORDS];

  // Next-state logic: FSM, decimation, frame/bank bookkeeping, handshake
  always_comb begin
    state_d          = state_q;
    wbank_d          = wbank_q;
    wr_frame_d       = wr_frame_q;
    chan_done_d      = chan_done_q;
    read_bank_d      = read_bank_q;
    overrun_d        = overrun_q;
    capture_active_d = capture_active_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      dcnt_d[c] = dcnt_q[c];
`ifdef DECIM_AVG_EN
      acc_d[c]  = acc_q[c];
`endif
    end
`ifdef DECIM_AVG_EN
    sum       = '0;
`endif
    fire      = 1'b0;
    we        = 1'b0;
    dec_val   = '0;
    wdata     = '0;
    waddr     = '0;
    done_next = chan_done_q;
    // A leaving FILL cycle accepts nothing: the partial frame is dropped.
    accept    = (state_q == FILL) && capture_en && sample_valid &&
                (32'(sample_ch) < NUM_CH);
    // Ack is applied before any swap decision made in the same cycle.
    ready_eff    = bank_ready_q & ~bank_ack;
    bank_ready_d = ready_eff;

    case (state_q)
      IDLE: begin
        if (capture_en) begin
          state_d          = FILL;
          capture_active_d = 1'b1;
        end
      end
      FILL: begin
        if (!capture_en) begin
          state_d          = IDLE;
          capture_active_d = 1'b0;
          wr_frame_d       = '0;
          chan_done_d      = '0;
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            dcnt_d[c] = '0;
`ifdef DECIM_AVG_EN
            acc_d[c]  = '0;
`endif
          end
        end else if (accept) begin
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sample_ch == CH_W'(c)) begin
              fire = (dcnt_q[c] == DEC_W'(DECIM - 1));
`ifdef DECIM_AVG_EN
              sum      = acc_q[c] + ACC_W'(sample_data);
              acc_d[c] = fire ? '0 : sum;
              dec_val  = DATA_W'(sum >> LOG2D);
`else
              dec_val  = sample_data;
`endif
              dcnt_d[c] = fire ? '0 : (dcnt_q[c] + 1'b1);
              if (fire) begin
                done_next[c] = 1'b1;
              end
            end
          end
          we    = fire;
          waddr = {wbank_q, wr_frame_q, sample_ch};
          wdata = dec_val;
          if (fire) begin
            if (&done_next) begin
              chan_done_d = '0;
              if (wr_frame_q == FR_W'(DEPTH - 1)) begin
                wr_frame_d = '0;
                if (ready_eff) begin
                  overrun_d = 1'b1;
                end else begin
                  wbank_d      = ~wbank_q;
                  read_bank_d  = wbank_q;
                  bank_ready_d = 1'b1;
                end
              end else begin
                wr_frame_d = wr_frame_q + 1'b1;
              end
            end else begin
              chan_done_d = done_next;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge CLK104MHZ or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      wbank_q          <= 1'b0;
      wr_frame_q       <= '0;
      chan_done_q      <= '0;
      bank_ready_q     <= 1'b0;
      read_bank_q      <= 1'b1;
      overrun_q        <= 1'b0;
      capture_active_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        dcnt_q[c] <= '0;
`ifdef DECIM_AVG_EN
        acc_q[c]  <= '0;
`endif
      end
    end else begin
      state_q          <= state_d;
      wbank_q          <= wbank_d;
      wr_frame_q       <= wr_frame_d;
      chan_done_q      <= chan_done_d;
      bank_ready_q     <= bank_ready_d;
      read_bank_q      <= read_bank_d;
      overrun_q        <= overrun_d;
      capture_active_q <= capture_active_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        dcnt_q[c] <= dcnt_d[c];
`ifdef DECIM_AVG_EN
        acc_q[c]  <= acc_d[c];
`endif
      end
    end
  end

  // Sample memory write port (no reset so it maps onto block RAM)
  always_ff @(posedge CLK104MHZ) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; output register clears on reset
  always_ff @(posedge CLK104MHZ or negedge rst) begin
    if (!rst) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= mem[{read_bank_q, read_frame, read_ch}];
    end
  end

  assign read_data      = read_data_q;
  assign bank_ready     = bank_ready_q;
  assign read_bank      = read_bank_q;
  assign overrun        = overrun_q;
  assign capture_active = capture_active_q;

endmodule

// File: tb/tb_multichannel_sample_collector.sv
// Bench for multichannel_sample_collector: instance A (2 ch, 4 frames,
// no decimation) is tracked cycle by cycle by a behavioural model; instance B
// (3 ch, 4 frames, decimate by 4) checks decimation and tag filtering.
module tb_multichannel_sample_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // ---------------- instance A ----------------
  logic        a_en, a_valid, a_ack;
  logic [0:0]  a_ch, a_rc;
  logic [11:0] a_data, a_rd;
  logic [1:0]  a_rf;
  logic        a_ready, a_rbank, a_ovr, a_act;

  multichannel_sample_collector #(
    .NUM_CH(2), .DATA_W(12), .DEPTH(4), .DECIM(1)
  ) dut_a (
    .CLK104MHZ(clk), .rst(rst_n), .capture_en(a_en),
    .sample_valid(a_valid), .sample_ch(a_ch), .sample_data(a_data),
    .read_frame(a_rf), .read_ch(a_rc), .read_data(a_rd),
    .bank_ready(a_ready), .read_bank(a_rbank), .bank_ack(a_ack),
    .overrun(a_ovr), .capture_active(a_act)
  );

  // ---------------- instance B ----------------
  logic        b_en, b_valid, b_ack;
  logic [1:0]  b_ch, b_rc, b_rf;
  logic [11:0] b_data, b_rd;
  logic        b_ready, b_rbank, b_ovr, b_act;

  multichannel_sample_collector #(
    .NUM_CH(3), .DATA_W(12), .DEPTH(4), .DECIM(4)
  ) dut_b (
    .CLK104MHZ(clk), .rst(rst_n), .capture_en(b_en),
    .sample_valid(b_valid), .sample_ch(b_ch), .sample_data(b_data),
    .read_frame(b_rf), .read_ch(b_rc), .read_data(b_rd),
    .bank_ready(b_ready), .read_bank(b_rbank), .bank_ack(b_ack),
    .overrun(b_ovr), .capture_active(b_act)
  );

  // ---------------- model of instance A ----------------
  bit          m_fill, m_wbank, m_rbank, m_ready, m_ovr;
  int          m_frame;
  bit [1:0]    m_done;
  logic [11:0] m_mem   [16];
  bit          m_known [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_wbank = 0; m_rbank = 1; m_ready = 0; m_ovr = 0;
    m_frame = 0; m_done = '0;
  endtask

  // One clock of instance A: model consumes current inputs, then compare.
  task automatic a_cycle();
    int          idx;
    logic [11:0] exp_rd;
    bit          rd_known, rdy_eff, acc;
    idx      = int'(m_rbank) * 8 + int'(a_rf) * 2 + int'(a_rc);
    exp_rd   = m_mem[idx];
    rd_known = m_known[idx];
    rdy_eff  = m_ready && !a_ack;
    acc      = m_fill && a_en && a_valid;
    if (m_fill && !a_en) begin
      m_frame = 0;
      m_done  = '0;
    end
    m_ready = rdy_eff;
    if (acc) begin
      idx = int'(m_wbank) * 8 + m_frame * 2 + int'(a_ch);
      m_mem[idx]   = a_data;
      m_known[idx] = 1;
      m_done[a_ch] = 1'b1;
      if (m_done == 2'b11) begin
        m_done = '0;
        if (m_frame == 3) begin
          m_frame = 0;
          if (!rdy_eff) begin
            m_rbank = m_wbank;
            m_wbank = !m_wbank;
            m_ready = 1;
          end else begin
            m_ovr = 1;
          end
        end else begin
          m_frame++;
        end
      end
    end
    m_fill = a_en;
    @(posedge clk);
    #1;
    check("a_capture_active", a_act, m_fill);
    check("a_bank_ready", a_ready, m_ready);
    check("a_read_bank", a_rbank, m_rbank);
    check("a_overrun", a_ovr, m_ovr);
    if (rd_known) check("a_read_data", a_rd, exp_rd);
  endtask

  task automatic a_sample(input int ch, input int data, input bit ack = 0);
    a_valid = 1; a_ch = ch[0:0]; a_data = data[11:0]; a_ack = ack;
    a_cycle();
    a_valid = 0; a_ack = 0;
  endtask

  task automatic a_read(input int f, input int c, input int exp, input string tag);
    a_rf = f[1:0]; a_rc = c[0:0];
    a_cycle();
    check(tag, a_rd, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_rd"}, a_rd, 0);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_a_rbank"}, a_rbank, 1);
    check({tag, "_a_ovr"}, a_ovr, 0);
    check({tag, "_a_act"}, a_act, 0);
    check({tag, "_b_rd"}, b_rd, 0);
    check({tag, "_b_ready"}, b_ready, 0);
    check({tag, "_b_rbank"}, b_rbank, 1);
    check({tag, "_b_ovr"}, b_ovr, 0);
    check({tag, "_b_act"}, b_act, 0);
  endtask

  logic [11:0] bv    [4][3][4];
  logic [11:0] b_exp [4][3];

  initial begin
    a_en = 0; a_valid = 0; a_ack = 0; a_ch = '0; a_data = '0; a_rf = '0; a_rc = '0;
    b_en = 0; b_valid = 0; b_ack = 0; b_ch = '0; b_data = '0; b_rf = '0; b_rc = '0;
    for (int i = 0; i < 16; i++) m_known[i] = 0;
    model_reset();
    rst_n = 1;
    #1 rst_n = 0;
    tick();
    tick();
    check_reset_outputs("reset");
    #4 rst_n = 1;
    tick();

    // Scenario 1: one full bank, alternating channels, data 1..8
    a_en = 1;
    a_cycle();
    for (int i = 0; i < 8; i++) a_sample(i % 2, i + 1);
    check("s1_ready", a_ready, 1);
    check("s1_rbank", a_rbank, 0);
    a_read(2, 1, 12'h006, "s1_read_f2c1");

    // Scenario 2: refill without ack -> overrun, reader bank untouched
    for (int i = 0; i < 8; i++) a_sample(i % 2, 'h11 + i);
    check("s2_ovr", a_ovr, 1);
    check("s2_rbank", a_rbank, 0);
    check("s2_ready", a_ready, 1);
    a_read(2, 1, 12'h006, "s2_read_f2c1");
    a_ack = 1;
    a_cycle();
    a_ack = 0;
    check("s2_ack_clears", a_ready, 0);

    // Scenario 3: ack on the exact completing cycle of the next swap
    for (int i = 0; i < 8; i++) a_sample(i % 2, 'h21 + i);
    check("s3_ready_pre", a_ready, 1);
    check("s3_rbank_pre", a_rbank, 1);
    for (int i = 0; i < 8; i++) a_sample(i % 2, 'h31 + i, (i == 7));
    check("s3_ready", a_ready, 1);
    check("s3_rbank", a_rbank, 0);
    check("s3_ovr", a_ovr, 1);
    a_read(0, 0, 12'h031, "s3_read_f0c0");

    // Scenario 4: drop capture after a ch0-only sample of frame 1
    a_ack = 1;
    a_cycle();
    a_ack = 0;
    a_sample(0, 'h041);
    a_sample(1, 'h042);
    a_sample(0, 'h0CC);
    a_en = 0;
    a_cycle();
    a_cycle();
    a_en = 1;
    a_cycle();
    a_sample(0, 'h0AA);
    a_sample(1, 'h0BB);
    for (int i = 0; i < 6; i++) a_sample(i % 2, 'h51 + i);
    check("s4_ready", a_ready, 1);
    check("s4_rbank", a_rbank, 1);
    a_read(0, 0, 12'h0AA, "s4_read_f0c0");
    a_read(0, 1, 12'h0BB, "s4_read_f0c1");
    a_read(1, 0, 12'h051, "s4_read_f1c0");

    // Scenario 5: decimate by 4 on instance B, with an out-of-range tag
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 3; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
          bv[f][c][k] = 12'($urandom_range(0, 4095));
          if (f == 0 && c == 0) bv[f][c][k] = 12'(4 * (k + 1));
          s += int'(bv[f][c][k]);
        end
`ifdef DECIM_AVG_EN
        b_exp[f][c] = 12'(s / 4);
`else
        b_exp[f][c] = bv[f][c][3];
`endif
      end
    b_en = 1;
    tick();
    check("s5_act", b_act, 1);
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 3; c++) begin
          b_valid = 1; b_ch = 2'(c); b_data = bv[f][c][k];
          tick();
          if (f == 0 && k == 1 && c == 0) begin
            b_ch = 2'd3; b_data = 12'hFFF;
            tick();
          end
        end
    b_valid = 0;
    tick();
    check("s5_ready", b_ready, 1);
    check("s5_rbank", b_rbank, 0);
    check("s5_ovr", b_ovr, 0);
    b_rf = 0; b_rc = 0;
    tick();
`ifdef DECIM_AVG_EN
    check("s5_decim_value", b_rd, 10);
`else
    check("s5_decim_value", b_rd, 16);
`endif
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 3; c++) begin
        b_rf = 2'(f); b_rc = 2'(c);
        tick();
        check($sformatf("s5_read_f%0dc%0d", f, c), b_rd, b_exp[f][c]);
      end

    // Scenario 6: asynchronous reset in the middle of a frame
    a_sample(0, 'h061);
    #2 rst_n = 0;
    #1;
    check_reset_outputs("s6_async");
    model_reset();
    b_en = 0;
    #2 rst_n = 1;
    tick();
    a_cycle();
    for (int i = 0; i < 8; i++) a_sample(i % 2, 'h71 + i);
    check("s6_ready", a_ready, 1);
    check("s6_rbank", a_rbank, 0);
    a_read(0, 0, 12'h071, "s6_read_f0c0");
    a_read(3, 1, 12'h078, "s6_read_f3c1");

    // Randomised traffic on instance A against the model
    for (int n = 0; n < 800; n++) begin
      a_en    = ($urandom_range(0, 39) != 0);
      a_valid = ($urandom_range(0, 9) < 7);
      a_ch    = 1'($urandom_range(0, 1));
      a_data  = 12'($urandom_range(0, 4095));
      a_ack   = ($urandom_range(0, 11) == 0);
      a_rf    = 2'($urandom_range(0, 3));
      a_rc    = 1'($urandom_range(0, 1));
      a_cycle();
    end
    a_valid = 0; a_ack = 0;
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 2; c++) begin
        a_rf = 2'(f); a_rc = 1'(c);
        a_cycle();
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
